// File: rtl/crossfade_pkg.sv
// rtl/crossfade_pkg.sv - shared crossfade types and constants
package crossfade_pkg;

    localparam int ALPHA_W = 5;
    localparam logic [ALPHA_W-1:0] ALPHA_ONE  = 5'd16;
    localparam logic [ALPHA_W-1:0] ALPHA_ZERO = 5'd0;

    typedef enum logic [1:0] {
        SETTLED_A = 2'd0,
        RAMP_UP   = 2'd1,
        SETTLED_B = 2'd2,
        RAMP_DOWN = 2'd3
    } xfade_state_t;

    function automatic logic is_endpoint(input logic [ALPHA_W-1:0] a);
        return (a == ALPHA_ZERO) || (a == ALPHA_ONE);
    endfunction

endpackage

// File: rtl/tick_counter.sv
// rtl/tick_counter.sv - loadable up/down counter advancing only when enabled
module tick_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            if (load)
                count <= load_value;
            else if (up)
                count <= count + WIDTH'(1);
            else
                count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/crossfade_sequencer.sv
// rtl/crossfade_sequencer.sv - tick-paced a/b crossfade weight sequencer with hold-off
module crossfade_sequencer
    import crossfade_pkg::*;
#(
    parameter int STEP_TICKS = 8,
    parameter int HOLD_TICKS = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_3M,
    input  logic               select_b,
    output logic [ALPHA_W-1:0] alpha_sequence,
    output logic               busy,
    output logic               active_b,
    output logic               done
);

    localparam int STEP_W = 8;
    localparam int HOLD_W = 10;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

    xfade_state_t       state, state_nxt;
    logic [ALPHA_W-1:0] alpha_nxt;
    logic [STEP_W-1:0]  step_count;
    logic [HOLD_W-1:0]  hold_count;
    logic               ramping, hold_zero, step_due;
    logic               start_up, start_dn, reverse, advance, finish;
    logic               step_en, step_load, hold_en, hold_load;

    assign ramping   = (state == RAMP_UP) || (state == RAMP_DOWN);
    assign hold_zero = (hold_count == '0);
    assign step_due  = (step_count == STEP_LAST);
    assign start_up  = (state == SETTLED_A) && hold_zero && select_b;
    assign start_dn  = (state == SETTLED_B) && hold_zero && !select_b;
    // A reversal wins over a step falling due on the same tick.
    assign reverse   = ((state == RAMP_UP) && !select_b) || ((state == RAMP_DOWN) && select_b);
    assign advance   = ramping && !reverse && step_due;

    always_comb begin
        alpha_nxt = alpha_sequence;
        state_nxt = state;
        case (state)
            SETTLED_A: if (start_up) begin
                alpha_nxt = 5'd1;
                state_nxt = RAMP_UP;
            end
            SETTLED_B: if (start_dn) begin
                alpha_nxt = ALPHA_ONE - 5'd1;
                state_nxt = RAMP_DOWN;
            end
            RAMP_UP: begin
                if (reverse) begin
                    alpha_nxt = alpha_sequence - 5'd1;
                    state_nxt = RAMP_DOWN;
                end else if (advance) begin
                    alpha_nxt = alpha_sequence + 5'd1;
                end
            end
            RAMP_DOWN: begin
                if (reverse) begin
                    alpha_nxt = alpha_sequence + 5'd1;
                    state_nxt = RAMP_UP;
                end else if (advance) begin
                    alpha_nxt = alpha_sequence - 5'd1;
                end
            end
            default: ;
        endcase
        // Any alpha move that lands on 0 or 16 ends the ramp, including a reversal step.
        finish = ramping && (reverse || advance) && is_endpoint(alpha_nxt);
        if (finish)
            state_nxt = (alpha_nxt == ALPHA_ONE) ? SETTLED_B : SETTLED_A;
    end

    assign step_en   = enable_3M && (start_up || start_dn || ramping);
    assign step_load = start_up || start_dn || reverse || advance;
    assign hold_en   = enable_3M && (finish || (!ramping && !hold_zero));
    assign hold_load = finish;

    tick_counter #(.WIDTH(STEP_W)) u_step_counter (
        .clk        (clk),
        .reset      (reset),
        .en         (step_en),
        .load       (step_load),
        .up         (1'b1),
        .load_value ('0),
        .count      (step_count)
    );

    tick_counter #(.WIDTH(HOLD_W)) u_hold_counter (
        .clk        (clk),
        .reset      (reset),
        .en         (hold_en),
        .load       (hold_load),
        .up         (1'b0),
        .load_value (HOLD_LOAD),
        .count      (hold_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= SETTLED_A;
            alpha_sequence <= ALPHA_ZERO;
            busy           <= 1'b0;
            active_b       <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (enable_3M) begin
                state          <= state_nxt;
                alpha_sequence <= alpha_nxt;
                busy           <= (state_nxt == RAMP_UP) || (state_nxt == RAMP_DOWN);
                active_b       <= (state_nxt == SETTLED_B);
                done           <= finish;
            end
        end
    end

    a_alpha_range: assert property (@(posedge clk) disable iff (!reset)
        alpha_sequence <= ALPHA_ONE);

endmodule

// File: tb/tb_crossfade_sequencer.sv
// tb/tb_crossfade_sequencer.sv - directed bench for crossfade_sequencer
module tb_crossfade_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable_3M = 1'b0;
    logic       select_b = 1'b0;
    logic [4:0] alpha_sequence;
    logic       busy, active_b, done;

    int checks = 0;
    int failures = 0;

    crossfade_sequencer #(.STEP_TICKS(2), .HOLD_TICKS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable_3M      (enable_3M),
        .select_b       (select_b),
        .alpha_sequence (alpha_sequence),
        .busy           (busy),
        .active_b       (active_b),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int a, input int b, input int ab, input int d);
        check({tag, ".alpha"}, 32'(alpha_sequence), 32'(a));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".active_b"}, 32'(active_b), 32'(ab));
        check({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic do_tick();
        @(negedge clk);
        enable_3M = 1'b1;
        @(negedge clk);
        enable_3M = 1'b0;
    endtask

    initial begin
        // reset held with random ticks
        for (int i = 0; i < 10; i++) begin
            select_b = 1'($urandom_range(0, 1));
            do_tick();
            check_all("reset_held", 0, 0, 0, 0);
        end
        @(negedge clk);
        reset = 1'b1;

        // full ramp up from A
        select_b = 1'b1;
        do_tick();
        check_all("up_entry", 1, 1, 0, 0);
        for (int k = 1; k <= 30; k++) begin
            do_tick();
            check_all("up_ramp", 1 + k / 2, (k < 30) ? 1 : 0, (k == 30) ? 1 : 0, (k == 30) ? 1 : 0);
        end
        @(negedge clk);
        check("done_one_clk", 32'(done), 32'(0));

        // hold-off in B, request A on first hold tick
        select_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_tick();
            check_all("hold_b", 16, 0, 1, 0);
        end
        do_tick();
        check_all("down_entry", 15, 1, 0, 0);
        for (int k = 1; k <= 30; k++) begin
            do_tick();
            check_all("down_ramp", 15 - k / 2, (k < 30) ? 1 : 0, 0, (k == 30) ? 1 : 0);
        end

        // hold-off in A, then restart
        select_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_tick();
            check_all("hold_a", 0, 0, 0, 0);
        end
        do_tick();
        check_all("up2_entry", 1, 1, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            do_tick();
            check("up2_ramp", 32'(alpha_sequence), 32'(1 + k / 2));
        end

        // reversal at alpha=8 with a step due on the same tick
        select_b = 1'b0;
        do_tick();
        check_all("reverse", 7, 1, 0, 0);
        for (int j = 1; j <= 14; j++) begin
            do_tick();
            check_all("rev_down", 7 - j / 2, (j < 14) ? 1 : 0, 0, (j == 14) ? 1 : 0);
        end

        select_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_tick();
            check("hold_a2", 32'(alpha_sequence), 32'(0));
        end
        do_tick();
        check_all("up3_entry", 1, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            do_tick();
            check("up3_ramp", 32'(alpha_sequence), 32'(1 + k / 2));
        end

        // freeze with enable_3M low
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 10) select_b = 1'b0;
            if (i == 40) select_b = 1'b1;
        end
        check_all("frozen", 3, 1, 0, 0);
        for (int k = 6; k <= 16; k++) begin
            do_tick();
            check_all("resume", 1 + k / 2, 1, 0, 0);
        end

        // asynchronous reset at alpha=9
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0);
        do_tick();
        check_all("reset_low_tick", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        do_tick();
        check_all("post_reset_entry", 1, 1, 0, 0);
        do_tick();
        check("post_reset_k1", 32'(alpha_sequence), 32'(1));
        do_tick();
        check("post_reset_k2", 32'(alpha_sequence), 32'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crossfade_sequencer.md
CROSSFADE_SEQUENCER -- requirements
Module: crossfade_sequencer

Interface
REQ-001 SHALL have parameter STEP_TICKS, default 8: enable_3M ticks between alpha steps; legal range 1..255.
REQ-002 SHALL have parameter HOLD_TICKS, default 64: enable_3M ticks of anti-chatter hold-off after a ramp completes; legal range 1..1023.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable_3M  input  1  single-clk tick strobe; all state advances only on clk edges with enable_3M=1.
REQ-006 SHALL have port select_b  input  1  requested channel (0=a, 1=b), synchronous to clk, sampled on ticks only.
REQ-007 SHALL have port alpha_sequence  output  5  crossfade weight, fixdt(0,5,4), range 0 (a) .. 16 (b), registered.
REQ-008 SHALL have port busy  output  1  high while in RAMP_UP or RAMP_DOWN.
REQ-009 SHALL have port active_b  output  1  high only in SETTLED_B.
REQ-010 SHALL have port done  output  1  one-clk pulse on the edge at which a ramp reaches its endpoint.

Function
REQ-011 SHALL implement FSM states SETTLED_A, RAMP_UP, SETTLED_B and RAMP_DOWN.
REQ-012 SHALL, in SETTLED_A, on a tick with select_b=1 and hold counter zero, enter RAMP_UP, set alpha to 1 and clear the step counter (first step on the entry tick).
REQ-013 SHALL, in RAMP_UP, increment the step counter per tick and, when it reaches STEP_TICKS-1, increment alpha and clear the counter.
REQ-014 SHALL, on the tick alpha becomes 16, enter SETTLED_B, load the hold counter with HOLD_TICKS and pulse done.
REQ-015 SHALL mirror REQ-012..014 for SETTLED_B (select_b=0) -> RAMP_DOWN -> SETTLED_A, with alpha decrementing to 0.
REQ-016 SHALL, on a tick during RAMP_UP with select_b=0, enter RAMP_DOWN, decrement alpha by 1 and clear the step counter (immediate reversal, no hold-off); RAMP_DOWN with select_b=1 SHALL mirror this.
REQ-017 SHALL, on a reversal, prioritise direction change over any step due on that same tick, so alpha moves exactly one LSB.
REQ-018 SHALL decrement the hold counter once per tick while non-zero in a SETTLED state, and ignore select_b until it reaches zero.
REQ-019 SHALL hold alpha within 0..16 by construction (no wrap); any value >16 is illegal and SHALL be flagged by an assertion.
REQ-020 SHALL take full-ramp duration 1+15*STEP_TICKS ticks (entry tick to endpoint tick, inclusive).
REQ-021 SHALL leave all registers unchanged on clk edges with enable_3M=0; done SHALL deassert on the next clk edge regardless of enable_3M.

Reset
REQ-022 SHALL, on reset low and asynchronously, force state SETTLED_A, alpha=0, busy=0, active_b=0, done=0, step counter=0 and hold counter=0.
REQ-023 SHALL, on reset mid-ramp, abort the ramp; after release, the first qualifying tick follows REQ-012.

Structure
REQ-024 SHALL place the FSM state enum, ALPHA_ONE=5'd16 and ALPHA_W=5 in a shared package crossfade_pkg, also used by progressive_mux instantiations.
REQ-025 SHALL use one sub-module, tick_counter (parameterised-width loadable down/up counter with enable), instantiated for the step counter and the hold counter; the FSM SHALL stay in the top.

Verification
REQ-026 SHALL verify the bench scenarios below with STEP_TICKS=2 and HOLD_TICKS=4:
- Reset held, random ticks -> alpha=0, busy=0, active_b=0, done=0 throughout.
- select_b=1 at tick t0 -> alpha=1 at t0, +1 every 2 ticks, alpha=16 at t0+30, done 1 clk, active_b=1, busy=0.
- At alpha=8 in RAMP_UP, select_b->0 -> same tick alpha=7, RAMP_DOWN, alpha=0 at 14 ticks later, SETTLED_A, done pulse.
- Settled in B, select_b->0 on first hold tick -> alpha stays 16 for 4 ticks; RAMP_DOWN entered on the tick after the hold counter reaches zero (alpha=15).
- Mid-ramp, enable_3M=0 for 50 clks -> alpha, state and counters frozen; ramp resumes with correct spacing.
- Reset asserted asynchronously at alpha=9 -> alpha=0 before the next clk edge; after release, a new ramp obeys REQ-012.
